// File: rtl/uart_rx_pkg.sv
// Shared widths, FSM state encoding and the parity helper for the UART frame buffer.
package uart_rx_pkg;

    localparam int unsigned FRAME_W    = 9;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned PERR_CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUSH = 2'd1,
        S_ACK  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    // 1 when the received parity bit does not match the expected sense.
    function automatic logic parity_err(input logic [FRAME_W-1:0] frame, input logic odd);
        return (^frame[DATA_W-1:0]) ^ frame[FRAME_W-1] ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_frame_buf_if.sv
// Receiver-side frame handshake, host read port and status signals of the frame buffer.
interface uart_rx_frame_buf_if;
    import uart_rx_pkg::*;

    logic                  frm_ready;
    logic [FRAME_W-1:0]    frm_data;
    logic                  frm_read;
    logic                  rd_en;
    logic                  rd_valid;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_perr;
    logic                  full;
    logic                  ovf;
    logic [PERR_CNT_W-1:0] perr_cnt;
    logic                  stat_clr;

    modport slave (
        input  frm_ready, frm_data, rd_en, stat_clr,
        output frm_read, rd_valid, rd_data, rd_perr, full, ovf, perr_cnt
    );

    modport master (
        output frm_ready, frm_data, rd_en, stat_clr,
        input  frm_read, rd_valid, rd_data, rd_perr, full, ovf, perr_cnt
    );

endinterface

// File: rtl/rx_fifo_core.sv
// Synchronous show-ahead FIFO; head output reads as zero while empty.
module rx_fifo_core #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned WIDTH  = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_frame_buf.sv
// UART receive frame buffer: captures frames, checks parity, acknowledges the
// receiver once per frame and buffers bytes for the host.
module uart_rx_frame_buf
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_W     = 3,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                clk_br,
    input  logic                rst_n,
    uart_rx_frame_buf_if.slave  bus
);

    state_t               state;
    state_t               state_nxt;
    logic [FRAME_W-1:0]   cap;
    logic                 perr;
    logic                 fifo_push;
    logic                 fifo_drop;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [FRAME_W-1:0]   fifo_dout;

    assign perr      = parity_err(cap, PARITY_ODD);
    assign fifo_push = (state == S_PUSH) && !fifo_full;
    assign fifo_drop = (state == S_PUSH) && fifo_full;
    assign fifo_pop  = bus.rd_en && !fifo_empty;

    always_ff @(posedge clk_br or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cap   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.frm_ready) begin
                cap <= bus.frm_data;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.frm_read = 1'b0;
        unique case (state)
            S_IDLE: if (bus.frm_ready) state_nxt = S_PUSH;
            S_PUSH: state_nxt = S_ACK;
            S_ACK: begin
                bus.frm_read = 1'b1;
                state_nxt    = S_WAIT;
            end
            S_WAIT: if (!bus.frm_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A new event in the same cycle as stat_clr takes precedence over the clear.
    always_ff @(posedge clk_br or negedge rst_n) begin
        if (!rst_n) begin
            bus.ovf      <= 1'b0;
            bus.perr_cnt <= '0;
        end else begin
            if (fifo_drop) begin
                bus.ovf <= 1'b1;
            end else if (bus.stat_clr) begin
                bus.ovf <= 1'b0;
            end

            if (fifo_push && perr) begin
                if (bus.stat_clr) begin
                    bus.perr_cnt <= PERR_CNT_W'(1);
                end else if (bus.perr_cnt != '1) begin
                    bus.perr_cnt <= bus.perr_cnt + 1'b1;
                end
            end else if (bus.stat_clr) begin
                bus.perr_cnt <= '0;
            end
        end
    end

    rx_fifo_core #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (FRAME_W)
    ) u_fifo (
        .clk   (clk_br),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({perr, cap[DATA_W-1:0]}),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus.rd_valid = !fifo_empty;
    assign bus.rd_data  = fifo_dout[DATA_W-1:0];
    assign bus.rd_perr  = fifo_dout[FRAME_W-1];
    assign bus.full     = fifo_full;

endmodule

// File: tb/tb_uart_rx_frame_buf.sv
// Scoreboard bench for uart_rx_frame_buf: directed frames queue expected bytes,
// a monitor compares every popped head against the queue.
module tb_uart_rx_frame_buf;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_rx_frame_buf_if bus();
    uart_rx_frame_buf_if bus_o();

    uart_rx_frame_buf #(.DEPTH(8), .ADDR_W(3), .PARITY_ODD(1'b0)) u_dut (
        .clk_br (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    uart_rx_frame_buf #(.DEPTH(8), .ADDR_W(3), .PARITY_ODD(1'b1)) u_dut_odd (
        .clk_br (clk),
        .rst_n  (rst_n),
        .bus    (bus_o)
    );

    logic odd_on;
    assign bus_o.frm_ready = odd_on & bus.frm_ready;
    assign bus_o.frm_data  = bus.frm_data;
    assign bus_o.stat_clr  = 1'b0;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    logic [8:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.frm_read === 1'b1) ack_cnt++;
    end

    always @(negedge clk) begin : monitor
        logic [8:0] e;
        if (rst_n && bus.rd_en && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h want no data", bus.rd_data);
            end else begin
                e = exp_q.pop_front();
                check("pop_data", 32'(bus.rd_data), 32'(e[7:0]));
                check("pop_perr", 32'(bus.rd_perr), 32'(e[8]));
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_frm_read"}, 32'(bus.frm_read), 0);
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
        check({tag, "_rd_data"},  32'(bus.rd_data),  0);
        check({tag, "_rd_perr"},  32'(bus.rd_perr),  0);
        check({tag, "_full"},     32'(bus.full),     0);
        check({tag, "_ovf"},      32'(bus.ovf),      0);
        check({tag, "_perr_cnt"}, 32'(bus.perr_cnt), 0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input bit store, input bit clr);
        int a0;
        bit seen;
        a0 = ack_cnt;
        @(posedge clk); #1;
        bus.frm_ready = 1'b1;
        bus.frm_data  = {par, d};
        if (store) exp_q.push_back({(^d) ^ par, d});
        if (clr) begin
            @(posedge clk); #1 bus.stat_clr = 1'b1;
            @(posedge clk); #1 bus.stat_clr = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (bus.frm_read === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no frm_read want one pulse");
        end
        @(posedge clk); #1 bus.frm_ready = 1'b0;
        @(posedge clk); #1;
        check("ack_per_frame", 32'(ack_cnt - a0), 1);
    endtask

    task automatic pop_n(input int n);
        @(posedge clk); #1 bus.rd_en = 1'b1;
        repeat (n) @(posedge clk);
        #1 bus.rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 bus.stat_clr = 1'b1;
        @(posedge clk); #1 bus.stat_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        rst_n         = 1'b0;
        bus.frm_ready = 1'b0;
        bus.frm_data  = '0;
        bus.rd_en     = 1'b0;
        bus.stat_clr  = 1'b0;
        bus_o.rd_en   = 1'b0;
        odd_on        = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        rst_n = 1'b1;

        // Test 1/2: good and bad even parity; odd build sees the opposite sense.
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        check("t1_rd_valid", 32'(bus.rd_valid), 1);
        check("t1_rd_data",  32'(bus.rd_data), 32'h55);
        check("t1_rd_perr",  32'(bus.rd_perr), 0);
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        check("t2_perr_cnt", 32'(bus.perr_cnt), 1);
        check("odd_head_data", 32'(bus_o.rd_data), 32'h55);
        check("odd_head_perr", 32'(bus_o.rd_perr), 1);
        @(posedge clk); #1 bus_o.rd_en = 1'b1;
        @(posedge clk); #1 bus_o.rd_en = 1'b0;
        check("odd_2nd_data", 32'(bus_o.rd_data), 32'h01);
        check("odd_2nd_perr", 32'(bus_o.rd_perr), 0);
        odd_on = 1'b0;
        pop_n(2);
        check("t2_drained", 32'(bus.rd_valid), 0);

        // stat_clr coincident with a parity-error push: the event wins.
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        check("clr_vs_perr", 32'(bus.perr_cnt), 1);
        pop_n(1);
        pulse_clr();
        check("clr_perr_cnt", 32'(bus.perr_cnt), 0);

        // Test 3: overflow on the ninth frame.
        a0 = ack_cnt;
        for (int i = 0; i < 8; i++) begin
            send_frame(8'(8'h10 + i), ^(8'(8'h10 + i)), 1'b1, 1'b0);
        end
        check("t3_full", 32'(bus.full), 1);
        check("t3_no_ovf_yet", 32'(bus.ovf), 0);
        send_frame(8'hEE, 1'b0, 1'b0, 1'b0);
        check("t3_acks", 32'(ack_cnt - a0), 9);
        check("t3_ovf", 32'(bus.ovf), 1);
        check("t3_full_kept", 32'(bus.full), 1);
        check("t3_head", 32'(bus.rd_data), 32'h10);
        pop_n(8);
        check("t3_empty", 32'(bus.rd_valid), 0);
        check("t3_not_full", 32'(bus.full), 0);
        check("t3_ovf_sticky", 32'(bus.ovf), 1);
        pulse_clr();
        check("t3_ovf_clr", 32'(bus.ovf), 0);

        // Test 4: ordering across pointer wrap with concurrent pops.
        for (int i = 0; i < 3; i++) send_frame(8'(i * 37 + 5), 1'(i), 1'b1, 1'b0);
        @(posedge clk); #1 bus.rd_en = 1'b1;
        for (int i = 3; i < 20; i++) send_frame(8'(i * 37 + 5), 1'(i), 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1 bus.rd_en = 1'b0;
        check("t4_queue_empty", 32'(exp_q.size()), 0);
        check("t4_rd_valid", 32'(bus.rd_valid), 0);

        // Test 5: frm_ready held high gives a single ack and push.
        a0 = ack_cnt;
        @(posedge clk); #1;
        bus.frm_ready = 1'b1;
        bus.frm_data  = {1'b0, 8'h3C};
        exp_q.push_back({1'b0, 8'h3C});
        repeat (50) @(posedge clk);
        #1;
        check("t5_one_ack", 32'(ack_cnt - a0), 1);
        check("t5_head", 32'(bus.rd_data), 32'h3C);
        bus.frm_ready = 1'b0;
        repeat (2) @(posedge clk);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        check("t5_two_acks", 32'(ack_cnt - a0), 2);
        pop_n(2);
        check("t5_drained", 32'(bus.rd_valid), 0);

        // Test 6: reset while the FSM is in PUSH.
        send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        check("t6_pre_valid", 32'(bus.rd_valid), 1);
        a0 = ack_cnt;
        @(posedge clk); #1;
        bus.frm_ready = 1'b1;
        bus.frm_data  = {1'b0, 8'h99};
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 check_reset_vals("t6_async");
        exp_q.delete();
        bus.frm_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_ack", 32'(ack_cnt - a0), 0);
        check("t6_empty", 32'(bus.rd_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
